// File: rtl/stack_pkg.sv
// stack_pkg: shared types and helpers for the 6502 stack sequencer.
//   op_e              stack operation encodings (6 and 7 are illegal)
//   state_e           sequencer states
//   DefaultStackPage  high address byte of the stack page
//   byte_count()      number of stack bytes moved by an op (0 for illegal ops)
package stack_pkg;

    typedef enum logic [2:0] {
        OpPush1   = 3'd0,
        OpPull1   = 3'd1,
        OpPushPc  = 3'd2,
        OpPullPc  = 3'd3,
        OpPushInt = 3'd4,
        OpPullInt = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StPush,
        StPull,
        StPullWait,
        StDone
    } state_e;

    localparam logic [7:0] DefaultStackPage = 8'h01;

    function automatic logic [1:0] byte_count(input logic [2:0] op);
        case (op)
            OpPush1, OpPull1:     return 2'd1;
            OpPushPc, OpPullPc:   return 2'd2;
            OpPushInt, OpPullInt: return 2'd3;
            default:              return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences the 6502 stack pointer and stack-page memory accesses for
// PHA/PHP, PLA/PLP, JSR/RTS, interrupt entry and RTI. S itself lives in an external
// byte register; this block only drives its load/data pins.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, op            op request (sampled in idle only) and op code
//   push_pc, push_byte   PC and A/P byte to push, captured at start
//   s_cur                current S register value
//   s_load, s_next       S register load enable and data
//   mem_addr             stack address {STACK_PAGE, ptr}
//   mem_we, mem_wdata    write strobe and data
//   mem_re, mem_rdata    read strobe; data returns the following cycle
//   busy, done, err      status; done/err are one-cycle pulses
//   pull_pc, pull_byte   restored PC and pulled byte, held from done until next start
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] STACK_PAGE = WIDTH'(DefaultStackPage)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [2*WIDTH-1:0]   push_pc,
    input  logic [WIDTH-1:0]     push_byte,
    input  logic [WIDTH-1:0]     s_cur,
    output logic                 s_load,
    output logic [WIDTH-1:0]     s_next,
    output logic [2*WIDTH-1:0]   mem_addr,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_re,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   pull_pc,
    output logic [WIDTH-1:0]     pull_byte
);

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [1:0]           cnt_q, cnt_d;
    // Push: bytes leave from the top. Pull: bytes enter at the top and shift down,
    // so after a full pull the layout is {PCH, PCL, P}.
    logic [3*WIDTH-1:0]   sr_q, sr_d;
    logic [2*WIDTH-1:0]   pull_pc_q, pull_pc_d;
    logic [WIDTH-1:0]     pull_byte_q, pull_byte_d;
    logic [1:0]           last_cnt;
    logic [WIDTH-1:0]     s_inc, s_dec;

    assign last_cnt = byte_count(op_q) - 2'd1;
    assign s_inc    = s_cur + WIDTH'(1);
    assign s_dec    = s_cur - WIDTH'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            cnt_q       <= '0;
            sr_q        <= '0;
            pull_pc_q   <= '0;
            pull_byte_q <= '0;
        end else begin
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            pull_pc_q   <= pull_pc_d;
            pull_byte_q <= pull_byte_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        pull_pc_d   = pull_pc_q;
        pull_byte_d = pull_byte_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    case (op)
                        OpPush1:   sr_d = {push_byte, {(2*WIDTH){1'b0}}};
                        OpPushPc:  sr_d = {push_pc, {WIDTH{1'b0}}};
                        OpPushInt: sr_d = {push_pc, push_byte};
                        default:   sr_d = '0;
                    endcase
                    if (byte_count(op) == 2'd0) begin
                        state_d = StDone;
                    end else if (op[0]) begin
                        state_d = StPull;
                    end else begin
                        state_d = StPush;
                    end
                end
            end
            StPush: begin
                sr_d  = {sr_q[2*WIDTH-1:0], {WIDTH{1'b0}}};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_cnt) begin
                    state_d = StDone;
                end
            end
            StPull: begin
                // Data for the read issued last cycle is on mem_rdata now.
                if (cnt_q != 2'd0) begin
                    sr_d = {mem_rdata, sr_q[3*WIDTH-1:WIDTH]};
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_cnt) begin
                    state_d = StPullWait;
                end
            end
            StPullWait: begin
                sr_d = {mem_rdata, sr_q[3*WIDTH-1:WIDTH]};
                if (op_q != OpPull1) begin
                    pull_pc_d = sr_d[3*WIDTH-1:WIDTH];
                end
                if (op_q == OpPull1) begin
                    pull_byte_d = sr_d[3*WIDTH-1:2*WIDTH];
                end else if (op_q == OpPullInt) begin
                    pull_byte_d = sr_d[WIDTH-1:0];
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        s_load    = 1'b0;
        s_next    = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        err       = (state_q == StDone) && (byte_count(op_q) == 2'd0);
        unique case (state_q)
            StPush: begin
                mem_we    = 1'b1;
                mem_addr  = {STACK_PAGE, s_cur};
                mem_wdata = sr_q[3*WIDTH-1:2*WIDTH];
                s_load    = 1'b1;
                s_next    = s_dec;
            end
            StPull: begin
                mem_re   = 1'b1;
                mem_addr = {STACK_PAGE, s_inc};
                s_load   = 1'b1;
                s_next   = s_inc;
            end
            default: begin
            end
        endcase
    end

    assign pull_pc   = pull_pc_q;
    assign pull_byte = pull_byte_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: randomized and directed checks of stack_ctrl against a byte-list
// reference model of the 6502 stack page, with an S register and memory model.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] push_pc;
    logic [7:0]  push_byte;
    logic [7:0]  s_reg;
    logic        s_load;
    logic [7:0]  s_next;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] pull_pc;
    logic [7:0]  pull_byte;

    // Environment controls.
    logic        s_force;
    logic [7:0]  s_force_val;
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [7:0]  tb_data;

    logic [7:0]  ram [0:65535];
    logic [7:0]  ref_mem [0:255];

    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int          rd_cnt;
    int          sl_cnt;
    int          both_cnt;
    int          idle_cnt;

    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .push_pc   (push_pc),
        .push_byte (push_byte),
        .s_cur     (s_reg),
        .s_load    (s_load),
        .s_next    (s_next),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pull_pc   (pull_pc),
        .pull_byte (pull_byte)
    );

    // S register and synchronous memory.
    always @(posedge clk) begin
        if (s_force) s_reg <= s_force_val;
        else if (s_load) s_reg <= s_next;
        if (tb_we) ram[{8'h01, tb_addr}] <= tb_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Bus monitor.
    always @(posedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (mem_re) rd_cnt = rd_cnt + 1;
        if (s_load) sl_cnt = sl_cnt + 1;
        if (mem_we && mem_re) both_cnt = both_cnt + 1;
        if (!busy && (s_load || mem_we || mem_re)) idle_cnt = idle_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        ref_mem[a] = d;
    endtask

    task automatic set_s(input logic [7:0] s0);
        @(negedge clk);
        tb_we       = 1'b0;
        s_force     = 1'b1;
        s_force_val = s0;
        @(negedge clk);
        s_force = 1'b0;
        wa_q.delete();
        wd_q.delete();
        rd_cnt = 0;
        sl_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_s_load"}, s_load, 0);
        check_eq({tag, "_mem_we"}, mem_we, 0);
        check_eq({tag, "_mem_re"}, mem_re, 0);
        check_eq({tag, "_pull_pc"}, pull_pc, 0);
        check_eq({tag, "_pull_byte"}, pull_byte, 0);
    endtask

    // One complete op against the reference model.
    task automatic run_op(input logic [2:0] o, input logic [15:0] pc, input logic [7:0] b,
                          input logic [7:0] s0);
        int          n;
        int          exp_done;
        int          cyc;
        bit          got_done;
        bit          bad;
        bit          is_pull;
        logic [7:0]  wb [$];
        logic [7:0]  rb [3];
        logic [7:0]  a;
        logic [7:0]  exp_s;
        logic [15:0] exp_pc;
        logic [7:0]  exp_byte;

        bad     = (o > 3'd5);
        is_pull = !bad && (o == 3'd1 || o == 3'd3 || o == 3'd5);
        n       = bad ? 0 : (o < 3'd2) ? 1 : (o < 3'd4) ? 2 : 3;
        exp_done = bad ? 1 : (is_pull ? n + 2 : n + 1);
        exp_s   = is_pull ? s0 + 8'(n) : s0 - 8'(n);
        exp_pc  = '0;
        exp_byte = '0;
        if (!bad && !is_pull) begin
            if (o != 3'd0) begin
                wb.push_back(pc[15:8]);
                wb.push_back(pc[7:0]);
            end
            if (o != 3'd2) wb.push_back(b);
        end
        for (int i = 0; i < 3; i++) begin
            a = s0 + 8'(i + 1);
            rb[i] = ref_mem[a];
        end
        if (o == 3'd1) exp_byte = rb[0];
        if (o == 3'd3) exp_pc = {rb[1], rb[0]};
        if (o == 3'd5) begin
            exp_byte = rb[0];
            exp_pc   = {rb[2], rb[1]};
        end

        set_s(s0);
        start     = 1'b1;
        op        = o;
        push_pc   = pc;
        push_byte = b;
        cyc       = 0;
        got_done  = 0;
        while (!got_done && cyc < 12) begin
            @(negedge clk);
            cyc       = cyc + 1;
            start     = 1'b0;
            op        = 3'($urandom);
            push_pc   = 16'($urandom);
            push_byte = 8'($urandom);
            if (done) got_done = 1;
        end
        check_eq("done_cycle", cyc, exp_done);
        if (got_done) begin
            check_eq("err", err, bad);
            check_eq("busy_at_done", busy, 1);
            if (o == 3'd1 || o == 3'd5) check_eq("pull_byte", pull_byte, exp_byte);
            if (o == 3'd3 || o == 3'd5) check_eq("pull_pc", pull_pc, exp_pc);
        end
        check_eq("s_final", s_reg, exp_s);
        check_eq("write_count", wa_q.size(), wb.size());
        for (int i = 0; i < wb.size() && i < wa_q.size(); i++) begin
            a = s0 - 8'(i);
            check_eq("write_addr", wa_q[i], {8'h01, a});
            check_eq("write_data", wd_q[i], wb[i]);
            ref_mem[a] = wb[i];
        end
        check_eq("read_count", rd_cnt, is_pull ? n : 0);
        check_eq("s_load_count", sl_cnt, n);
        @(negedge clk);
        check_eq("busy_after", busy, 0);
        check_eq("done_after", done, 0);
    endtask

    initial begin
        int         cyc;
        bit         got;
        logic [7:0] s0;

        n_checks    = 0;
        n_fail      = 0;
        rd_cnt      = 0;
        sl_cnt      = 0;
        both_cnt    = 0;
        idle_cnt    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        op          = '0;
        push_pc     = '0;
        push_byte   = '0;
        s_force     = 1'b0;
        s_force_val = '0;
        tb_we       = 1'b0;
        tb_addr     = '0;
        tb_data     = '0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

        // PUSH_PC from S=FD.
        run_op(3'd2, 16'h1234, 8'h00, 8'hFD);
        check_eq("t1_mem_01fd", ram[16'h01FD], 8'h12);
        check_eq("t1_mem_01fc", ram[16'h01FC], 8'h34);

        // PULL_INT with a preloaded frame.
        poke(8'hFB, 8'h24);
        poke(8'hFC, 8'h00);
        poke(8'hFD, 8'hC0);
        run_op(3'd5, 16'h0000, 8'h00, 8'hFA);
        check_eq("t2_pull_byte_held", pull_byte, 8'h24);
        check_eq("t2_pull_pc_held", pull_pc, 16'hC000);

        // Wraparound both ways.
        run_op(3'd0, 16'h0000, 8'hAA, 8'h00);
        check_eq("t3_mem_0100", ram[16'h0100], 8'hAA);
        run_op(3'd1, 16'h0000, 8'h00, 8'hFF);
        check_eq("t3_pull_byte", pull_byte, 8'hAA);

        // Illegal op.
        run_op(3'd7, 16'hFFFF, 8'hFF, 8'h80);

        // Start held high: second op only after done.
        set_s(8'hFD);
        start = 1'b1; op = 3'd4; push_pc = 16'hBEEF; push_byte = 8'h5A;
        cyc = 0; got = 0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (done) got = 1;
        end
        check_eq("t5_done_cycle", cyc, 4);
        check_eq("t5_writes_first", wa_q.size(), 3);
        @(negedge clk);
        check_eq("t5_idle_gap", busy, 0);
        @(negedge clk);
        check_eq("t5_restart", busy, 1);
        start = 1'b0;
        cyc = 1; got = 0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (done) got = 1;
        end
        check_eq("t5_done_cycle2", cyc, 4);
        check_eq("t5_writes_total", wa_q.size(), 6);
        check_eq("t5_s_final", s_reg, 8'hF7);
        for (int i = 0; i < 6; i++) begin
            s0 = 8'hFD - 8'(i);
            ref_mem[s0] = (i % 3 == 0) ? 8'hBE : (i % 3 == 1) ? 8'hEF : 8'h5A;
        end

        // Reset in cycle 2 of PUSH_INT.
        set_s(8'hFD);
        start = 1'b1; op = 3'd4; push_pc = 16'h1357; push_byte = 8'h9A;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_abort");
        check_eq("t6_writes", wa_q.size(), 2);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_writes_later", wa_q.size(), 2);
        check_eq("t6_busy_later", busy, 0);
        check_eq("t6_s_final", s_reg, 8'hFB);
        ref_mem[8'hFD] = 8'h13;
        ref_mem[8'hFC] = 8'h57;

        // Randomized ops, biased toward the S wrap points.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) s0 = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF;
            else s0 = 8'($urandom);
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), s0);
        end

        check_eq("we_re_overlap", both_cnt, 0);
        check_eq("strobe_while_idle", idle_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
